// File: rtl/fp_int_wb_buffer_if.sv
// Handshake bundle between the FP result source, the
// writeback buffer and integer writeback.
interface fp_int_wb_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [31:0]     in_data;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_we;

  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_rd,
    input  out_we
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  in_rd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_rd,
    output out_we
  );
endinterface

// File: rtl/fp_int_wb_buffer.sv
// FP-to-integer writeback buffer: converts FCLASS/FMV/compare
// results at enqueue and queues them for integer writeback.
module fp_int_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  fp_int_wb_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        cv;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          op_cls;
  logic          op_mv;
  logic          op_cmp;

  assign op_cls = bus.in_op == 2'd0;
  assign op_mv  = bus.in_op == 2'd1;
  assign op_cmp = bus.in_op == 2'd2;

  always_comb begin
    cv      = '0;
    cv.rd   = bus.in_rd;
    cv.we   = (bus.in_rd != 5'd0) &&
              (bus.in_op != 2'd3);
    unique case (1'b1)
      op_cls: begin
        if (bus.in_data < 32'd10)
          cv.data = XLEN'(1) << bus.in_data[3:0];
      end
      op_mv:   cv.data = XLEN'(bus.in_data);
      op_cmp:  cv.data = XLEN'(bus.in_data[0]);
      default: cv.data = '0;
    endcase
  end

  // in_ready never looks at out_ready: no pass-through when full
  assign bus.in_ready = (count < CW'(DEPTH)) && !flush;
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cv;
  end

  assign head = mem[rd_ptr];
  assign bus.out_data =
    bus.out_valid ? head.data : '0;
  assign bus.out_rd =
    bus.out_valid ? head.rd : 5'd0;
  assign bus.out_we =
    bus.out_valid && head.we;
endmodule

// File: tb/tb_fp_int_wb_buffer.sv
// Randomised and directed bench for fp_int_wb_buffer against
// a queue-based reference model.
module tb_fp_int_wb_buffer;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  fp_int_wb_buffer_if #(.XLEN(XLEN)) bus ();

  fp_int_wb_buffer #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   acc;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic ent_t conv(logic [1:0]  op,
                                logic [31:0] d,
                                logic [4:0]  rd);
    ent_t e;
    e.rd = rd;
    e.we = (rd != 0) && (op != 2'd3);
    case (op)
      2'd0:    e.data = (d <= 9) ? (32'd1 << d) : 32'd0;
      2'd1:    e.data = d;
      2'd2:    e.data = d & 32'd1;
      default: e.data = 32'd0;
    endcase
    return e;
  endfunction

  task automatic drive(bit v, logic [1:0] op,
                       logic [31:0] d, logic [4:0] rd,
                       bit ordy, bit fl, bit rst);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_data   = d;
    bus.in_rd     = rd;
    bus.out_ready = ordy;
    flush         = fl;
    resetn        = rst;
  endtask

  task automatic cycle();
    ent_t h;
    bit   push;
    bit   pop;
    @(negedge clk);
    h.data = 0;
    h.rd   = 0;
    h.we   = 0;
    if (q.size() != 0) h = q[0];
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(bus.in_ready),
          32'((q.size() < DEPTH) && !flush));
    check("out_valid", 32'(bus.out_valid),
          32'(q.size() != 0));
    check("out_data", bus.out_data, h.data);
    check("out_rd", 32'(bus.out_rd), 32'(h.rd));
    check("out_we", 32'(bus.out_we), 32'(h.we));
    push = bus.in_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() != 0) && bus.out_ready;
    acc  = push;
    if (resetn || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push)
        q.push_back(conv(bus.in_op, bus.in_data,
                         bus.in_rd));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          v;
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  rd;

    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    cycle();
    drive(0, 0, 0, 0, 1, 0, 0);
    cycle();
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);

    drive(1, 0, 7, 5, 1, 0, 0);
    cycle();
    check("fcls_valid", 32'(bus.out_valid), 32'd1);
    check("fcls_data", bus.out_data, 32'h80);
    check("fcls_rd", 32'(bus.out_rd), 32'd5);
    check("fcls_we", 32'(bus.out_we), 32'd1);
    drive(1, 0, 12, 3, 1, 0, 0);
    cycle();
    check("bad_idx", bus.out_data, 32'd0);
    check("bad_idx_rd", 32'(bus.out_rd), 32'd3);
    drive(1, 2, 32'hFFFF_FFFF, 0, 1, 0, 0);
    cycle();
    check("cmp_data", bus.out_data, 32'd1);
    check("cmp_we", 32'(bus.out_we), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    cycle();

    drive(1, 1, 32'h3F80_0000, 1, 0, 0, 0);
    cycle();
    drive(1, 1, 32'hBF80_0000, 2, 0, 0, 0);
    cycle();
    check("full_cnt", 32'(count), 32'd2);
    check("full_rdy", 32'(bus.in_ready), 32'd0);
    drive(1, 1, 32'h1234_5678, 3, 0, 0, 0);
    cycle();
    check("full_hold", 32'(count), 32'd2);
    check("bp_head", bus.out_data, 32'h3F80_0000);
    drive(0, 0, 0, 0, 1, 0, 0);
    cycle();
    check("bp_second", bus.out_data, 32'hBF80_0000);
    cycle();
    check("bp_empty", 32'(count), 32'd0);

    drive(1, 1, 32'hA0, 9, 0, 0, 0);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 32'hA0 + i, 5'(i), 1, 0, 0);
      cycle();
      check("cc_count", 32'(count), 32'd1);
      check("cc_rd", 32'(bus.out_rd), 32'(i));
    end

    drive(1, 1, 32'h5, 4, 0, 0, 0);
    cycle();
    check("fl_pre", 32'(count), 32'd2);
    drive(1, 1, 32'h6, 6, 0, 1, 0);
    cycle();
    check("fl_cnt", 32'(count), 32'd0);
    check("fl_valid", 32'(bus.out_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("fl_noenq", 32'(count), 32'd0);

    drive(1, 1, 32'h7, 7, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    check("rm_valid", 32'(bus.out_valid), 32'd0);
    check("rm_data", bus.out_data, 32'd0);
    check("rm_cnt", 32'(count), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rm_ready", 32'(bus.in_ready), 32'd1);
    cycle();

    v = 0; op = 0; d = 0; rd = 0; acc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(v && !acc)) begin
        v  = $urandom_range(0, 3) != 0;
        op = 2'($urandom_range(0, 3));
        d  = (op == 2'd0) ? 32'($urandom_range(0, 15))
                          : $urandom;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0
             : 5'($urandom_range(1, 31));
      end
      drive(v, op, d, rd,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 59) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_int_wb_buffer.md
Name: fp_int_wb_buffer

Overview:
- Downstream stage of the FP classify unit.
- Accepts FPU results bound for the integer register file: FCLASS class index, FMV.X.W raw bits, and FEQ/FLT/FLE compare bits.
- Converts each result to RISC-V integer format and buffers it in a small FIFO.
- Presents results to integer writeback with a valid/ready handshake.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, >= 2)
- XLEN, 32, integer result width

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  synchronous reset, active-high: 1 = reset, sampled on rising clk
- flush  input  1  synchronous pipeline flush; discards all buffered entries
- in_valid  input  1  upstream result valid
- in_ready  output  1  buffer can accept an entry this cycle
- in_op  input  2  0 = FCLASS index, 1 = FMV.X.W, 2 = compare, 3 = reserved
- in_data  input  32  raw result: class index 0..9, FP bits, or compare bit in [0]
- in_rd  input  5  destination integer register
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback accepts head entry
- out_data  output  XLEN  converted result
- out_rd  output  5  destination register of head entry
- out_we  output  1  register-file write enable of head entry
- count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Conversion is applied at enqueue; the FIFO stores converted data, rd and we.
- FCLASS (op 0): out_data = one-hot mask with bit[in_data] = 1, bits 10..XLEN-1 = 0.
  - in_data > 9 gives out_data = 0.
  - Index meaning: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- FMV.X.W (op 1): out_data = in_data unchanged.
- Compare (op 2): out_data = {31'b0, in_data[0]}; upper input bits are ignored.
- Reserved (op 3): out_data = 0, we = 0. The entry is still enqueued and retired.
- we = 1 only when in_rd != 0 and op != 3. rd = 0 entries are retired with out_we = 0.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. It depends only on registered state and flush, never on out_ready; there is no full-buffer pass-through.
- out_valid = (count != 0). out_data, out_rd and out_we are driven from the head entry.
- When out_valid = 0, out_data = 0, out_rd = 0 and out_we = 0.
- Latency: an entry accepted in cycle N appears at the head in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Full (count = DEPTH): in_ready = 0; in_valid is ignored.
- Empty: out_ready is ignored; count does not underflow.
- Upstream must hold in_valid, in_op, in_data and in_rd stable until accepted. Downstream may deassert out_ready at any time without loss.
- flush = 1: next cycle count = 0 and pointers = 0.
  - Any push or pop in the same cycle is discarded.
  - resetn has priority over flush.
- resetn = 1: next cycle count = 0, pointers = 0, out_valid = 0, out_data = 0, out_rd = 0, out_we = 0.
  - Reset mid-transfer drops all buffered entries.
  - in_ready is 1 the cycle after resetn deasserts, provided flush = 0.
- FIFO entry storage is not required to be cleared on reset or flush; only the occupancy state is.

Test Plan:
- FCLASS one-hot: push op 0, data 7, rd 5 with out_ready = 1 -> next cycle out_valid = 1, out_data = 0x00000080, out_rd = 5, out_we = 1.
- Bad index and rd0: push op 0, data 12, rd 3 -> out_data = 0. Then push op 2, data 0xFFFFFFFF, rd 0 -> out_data = 0x00000001, out_we = 0.
- Backpressure and full: out_ready = 0; push FMV.X.W values 0x3F800000 and 0xBF800000 -> count = 2, in_ready = 0; a third push is ignored. Then release out_ready = 1 -> outputs appear in order over 2 cycles, count returns to 0.
- Concurrent push/pop: hold count = 1 and push/pop every cycle for 8 cycles with rd 1..8 -> count stays 1, outputs appear in order, pointers wrap with no loss or duplication.
- Flush: with count = 2, assert flush together with in_valid = 1 -> next cycle count = 0, out_valid = 0, flushed-cycle input not enqueued.
- Reset mid-operation: with count = 1, drive resetn = 1 for one cycle -> out_valid = 0, out_data = 0, count = 0; in_ready = 1 the following cycle.
